data_mem_responder: RTL and testbench

Memory-side responder for the pipeline's MEM-stage data port. It accepts one word-addressed read or write request at a time over a valid/ready handshake and performs it after a fixed, parameterised access latency. It returns a one-cycle response pulse and drives a stall signal that freezes the pipeline while the access is outstanding. It sits between the EXE/MEM pipeline register outputs (address, store data, MemRead/MemWrite) and the MEM/WB register's read-data input.

---
 rtl/data_mem_responder.sv | 134 +++++++++++++
 tb/tb_data_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a valid/ready request port.
// Each access takes a fixed LATENCY of wait cycles, then a one-cycle response.
module data_mem_responder #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 mem_we_s;
  logic                 oor_s;
  logic [ADDR_BITS-1:0] index_s;
  logic [31:0]          mem_q [DEPTH];

  // Any set bit above the index field means the address is outside the array.
  function automatic logic out_of_range(input logic [31:0] addr);
    return (addr >> ADDR_BITS) != 32'd0;
  endfunction

  assign index_s = addr_q[ADDR_BITS-1:0];
  assign oor_s   = out_of_range(addr_q);

  // Next-state logic: capture in IDLE, count down in WAIT, commit the access on the last WAIT edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = oor_s;
          if (write_q) begin
            mem_we_s = !oor_s;
          end else if (oor_s) begin
            rdata_d = 32'd0;
          end else begin
            rdata_d = mem_q[index_s];
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = err_q;
    resp_rdata = rdata_q;
    stall      = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
  end

  // Control and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[index_s] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances (LATENCY 2, 1, 15)
// driven by scenario tasks and compared against an array-based reference model.
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        req_ready_w  [3];
  logic        resp_valid_w [3];
  logic [31:0] resp_rdata_w [3];
  logic        resp_err_w   [3];
  logic        stall_w      [3];

  int          lat_tab [3] = '{2, 1, 15};
  logic [31:0] model_mem  [3][256];
  logic [31:0] last_rdata [3];
  int          checks = 0;
  int          errors = 0;

  data_mem_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(2)) u_dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready_w[0]),
    .resp_valid(resp_valid_w[0]), .resp_rdata(resp_rdata_w[0]), .resp_err(resp_err_w[0]),
    .stall(stall_w[0]));

  data_mem_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready_w[1]),
    .resp_valid(resp_valid_w[1]), .resp_rdata(resp_rdata_w[1]), .resp_err(resp_err_w[1]),
    .stall(stall_w[1]));

  data_mem_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(15)) u_dut2 (
    .clock(clock), .reset(reset), .req_valid(req_valid[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready_w[2]),
    .resp_valid(resp_valid_w[2]), .resp_rdata(resp_rdata_w[2]), .resp_err(resp_err_w[2]),
    .stall(stall_w[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: an access updates the array or the last read data in one step.
  task automatic model_access(input int d, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] exp_rdata,
                              output logic exp_err);
    exp_err = (addr >= 32'd256);
    if (exp_err) begin
      if (!wr) last_rdata[d] = 32'd0;
    end else if (wr) begin
      model_mem[d][addr[7:0]] = wdata;
    end else begin
      last_rdata[d] = model_mem[d][addr[7:0]];
    end
    exp_rdata = last_rdata[d];
  endtask

  // Presents one request in cycle 0 (held for 'hold' cycles) and observes cycles 0..lat+1.
  task automatic run_req(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         output int resp_cyc, output int resp_cnt, output int stall_mask,
                         output int ready_mask, output logic [31:0] rdata, output logic err,
                         output bit rdata_stable);
    int lat;
    lat = lat_tab[d];
    resp_cyc = -1; resp_cnt = 0; stall_mask = 0; ready_mask = 0;
    rdata = 32'd0; err = 1'b0; rdata_stable = 1'b1;
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata;
    for (int k = 0; k < lat + 2; k++) begin
      @(negedge clock);
      if (stall_w[d] === 1'b1) stall_mask |= (1 << k);
      if (req_ready_w[d] === 1'b1) ready_mask |= (1 << k);
      if (resp_valid_w[d] === 1'b1) begin
        resp_cnt++;
        if (resp_cyc < 0) begin
          resp_cyc = k; rdata = resp_rdata_w[d]; err = resp_err_w[d];
        end
      end else if (resp_rdata_w[d] !== last_rdata[d]) begin
        rdata_stable = 1'b0;
      end
      @(posedge clock); #1;
      if (k + 1 >= hold) begin
        req_valid[d] = 1'b0; req_write[d] = 1'($urandom);
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b1; #1;
      checks++; if (stall_w[d] !== 1'b1) begin errors++; $display("FAIL reset_stall_hi[%0d]: got %b want 1", d, stall_w[d]); end
      req_valid[d] = 1'b0; #1;
      checks++; if (stall_w[d] !== 1'b0) begin errors++; $display("FAIL reset_stall_lo[%0d]: got %b want 0", d, stall_w[d]); end
      checks++; if (req_ready_w[d] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", d, req_ready_w[d]); end
      checks++; if (resp_valid_w[d] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid[%0d]: got %b want 0", d, resp_valid_w[d]); end
      checks++; if (resp_err_w[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", d, resp_err_w[d]); end
      checks++; if (resp_rdata_w[d] !== 32'd0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, resp_rdata_w[d]); end
      last_rdata[d] = 32'd0;
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_preload;
    int rc, rn, sm, rm; logic [31:0] rd, er; logic e, ee; bit st;
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 16; a++) begin
        logic [31:0] wv;
        wv = $urandom;
        run_req(d, 1'b1, 32'(a), wv, 1, rc, rn, sm, rm, rd, e, st);
        model_access(d, 1'b1, 32'(a), wv, er, ee);
        checks++; if (rc != lat_tab[d] + 1 || rn != 1) begin errors++; $display("FAIL preload_timing[%0d]: resp cycle %0d count %0d want %0d/1", d, rc, rn, lat_tab[d] + 1); end
        checks++; if (e !== ee) begin errors++; $display("FAIL preload_err[%0d]: got %b want %b", d, e, ee); end
      end
    end
  endtask

  task automatic test_write_read;
    int rc, rn, sm, rm; logic [31:0] rd, er; logic e, ee; bit st;
    run_req(0, 1'b1, 32'd5, 32'hDEADBEEF, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b1, 32'd5, 32'hDEADBEEF, er, ee);
    checks++; if (rc != 3 || rn != 1) begin errors++; $display("FAIL wr_resp_cycle: cycle %0d count %0d want 3/1", rc, rn); end
    checks++; if (sm != 32'b0111) begin errors++; $display("FAIL wr_stall_pattern: got %b want 0111", sm); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", e); end
    checks++; if (rd !== er || !st) begin errors++; $display("FAIL wr_rdata_held: got %h stable %0d want %h", rd, st, er); end
    run_req(0, 1'b0, 32'd5, 32'h0, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b0, 32'd5, 32'h0, er, ee);
    checks++; if (rc != 3 || rn != 1) begin errors++; $display("FAIL rd_resp_cycle: cycle %0d count %0d want 3/1", rc, rn); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_held_request;
    int rc, rn, sm, rm; logic [31:0] rd, er; logic e, ee; bit st;
    run_req(0, 1'b0, 32'd7, 32'h0, 4, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b0, 32'd7, 32'h0, er, ee);
    checks++; if (rn != 1 || rc != 3) begin errors++; $display("FAIL held_one_resp: count %0d cycle %0d want 1/3", rn, rc); end
    checks++; if (rm != 32'b0001) begin errors++; $display("FAIL held_ready: got %b want 0001", rm); end
    checks++; if (rd !== er) begin errors++; $display("FAIL held_rdata: got %h want %h", rd, er); end
    @(negedge clock);
    checks++; if (req_ready_w[0] !== 1'b1 || resp_valid_w[0] !== 1'b0 || stall_w[0] !== 1'b0) begin
      errors++; $display("FAIL held_idle_after: ready %b resp %b stall %b want 1/0/0", req_ready_w[0], resp_valid_w[0], stall_w[0]);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_out_of_range;
    int rc, rn, sm, rm; logic [31:0] rd, er; logic e, ee; bit st;
    logic [31:0] prior;
    prior = model_mem[0][0];
    run_req(0, 1'b1, 32'h100, 32'h12345678, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b1, 32'h100, 32'h12345678, er, ee);
    checks++; if (e !== 1'b1 || rc != 3) begin errors++; $display("FAIL oor_wr_err: err %b cycle %0d want 1/3", e, rc); end
    run_req(0, 1'b0, 32'h0, 32'h0, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b0, 32'h0, 32'h0, er, ee);
    checks++; if (rd !== prior || e !== 1'b0) begin errors++; $display("FAIL oor_no_wrap: got %h err %b want %h/0", rd, e, prior); end
    run_req(0, 1'b0, 32'h100, 32'h0, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b0, 32'h100, 32'h0, er, ee);
    checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL oor_rd: got %h err %b want 0/1", rd, e); end
    run_req(0, 1'b0, 32'h8000_0003, 32'h0, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b0, 32'h8000_0003, 32'h0, er, ee);
    checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL oor_rd_high: got %h err %b want 0/1", rd, e); end
  endtask

  task automatic test_reset_mid;
    int rc, rn, sm, rm, seen; logic [31:0] rd, er; logic e, ee; bit st;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'd9; req_wdata[0] = 32'hAAAA5555;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (req_ready_w[0] !== 1'b1 || resp_valid_w[0] !== 1'b0 || resp_err_w[0] !== 1'b0 ||
                  resp_rdata_w[0] !== 32'd0 || stall_w[0] !== 1'b0) begin
      errors++; $display("FAIL rst_async: ready %b resp %b err %b rdata %h stall %b want 1/0/0/0/0",
                         req_ready_w[0], resp_valid_w[0], resp_err_w[0], resp_rdata_w[0], stall_w[0]);
    end
    for (int d = 0; d < 3; d++) last_rdata[d] = 32'd0;
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (resp_valid_w[0] === 1'b1) seen++;
    end
    @(posedge clock); #1;
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_resp: got %0d pulses want 0", seen); end
    run_req(0, 1'b0, 32'd9, 32'h0, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b0, 32'd9, 32'h0, er, ee);
    checks++; if (rd !== er) begin errors++; $display("FAIL rst_write_dropped: got %h want %h", rd, er); end
  endtask

  task automatic test_latency_sweep(input int d);
    int lat, per, accepted, seen, bad_stall, bad_resp, bad_data;
    logic [31:0] exp_q [$];
    logic [31:0] er; logic ee;
    lat = lat_tab[d]; per = lat + 2;
    accepted = 0; seen = 0; bad_stall = 0; bad_resp = 0; bad_data = 0;
    req_valid[d] = 1'b1; req_write[d] = 1'b0; req_addr[d] = 32'd0;
    for (int k = 0; k < 4 * per; k++) begin
      @(negedge clock);
      if (stall_w[d] !== ((k % per) <= lat)) bad_stall++;
      if (resp_valid_w[d] === 1'b1) begin
        seen++;
        if ((k % per) != lat + 1) bad_resp++;
        if (exp_q.size() == 0) bad_data++;
        else if (resp_rdata_w[d] !== exp_q.pop_front()) bad_data++;
      end else if ((k % per) == lat + 1) begin
        bad_resp++;
      end
      if ((k % per) == 0) begin
        model_access(d, 1'b0, req_addr[d], 32'h0, er, ee);
        exp_q.push_back(er);
      end
      @(posedge clock); #1;
      if ((k % per) == 0) begin
        accepted++;
        if (accepted < 4) req_addr[d] = 32'(accepted);
        else req_valid[d] = 1'b0;
      end
    end
    checks++; if (seen != 4) begin errors++; $display("FAIL sweep_count[lat%0d]: got %0d want 4", lat, seen); end
    checks++; if (bad_resp != 0) begin errors++; $display("FAIL sweep_spacing[lat%0d]: got %0d bad cycles want 0", lat, bad_resp); end
    checks++; if (bad_stall != 0) begin errors++; $display("FAIL sweep_stall[lat%0d]: got %0d bad cycles want 0", lat, bad_stall); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL sweep_data[lat%0d]: got %0d bad reads want 0", lat, bad_data); end
  endtask

  task automatic test_rdata_hold;
    int rc, rn, sm, rm; logic [31:0] rd, er; logic e, ee; bit st;
    run_req(0, 1'b1, 32'd3, 32'h11, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b1, 32'd3, 32'h11, er, ee);
    run_req(0, 1'b0, 32'd3, 32'h0, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b0, 32'd3, 32'h0, er, ee);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL hold_first_read: got %h want 11", rd); end
    run_req(0, 1'b1, 32'd3, 32'h22, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b1, 32'd3, 32'h22, er, ee);
    checks++; if (rd !== 32'h11 || !st) begin errors++; $display("FAIL hold_through_write: got %h stable %0d want 11", rd, st); end
    @(negedge clock);
    checks++; if (resp_rdata_w[0] !== 32'h11) begin errors++; $display("FAIL hold_after_write: got %h want 11", resp_rdata_w[0]); end
    @(posedge clock); #1;
    run_req(0, 1'b0, 32'd3, 32'h0, 1, rc, rn, sm, rm, rd, e, st);
    model_access(0, 1'b0, 32'd3, 32'h0, er, ee);
    checks++; if (rd !== 32'h22) begin errors++; $display("FAIL hold_next_read: got %h want 22", rd); end
  endtask

  task automatic test_random;
    int rc, rn, sm, rm; logic [31:0] rd, er; logic e, ee; bit st;
    logic wr; logic [31:0] addr, wv;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 15));
      wv = $urandom;
      run_req(0, wr, addr, wv, 1, rc, rn, sm, rm, rd, e, st);
      model_access(0, wr, addr, wv, er, ee);
      checks++; if (rc != 3 || rn != 1 || sm != 32'b0111) begin
        errors++; $display("FAIL rand_timing[%0d]: cycle %0d count %0d stall %b want 3/1/0111", i, rc, rn, sm);
      end
      checks++; if (rd !== er || e !== ee || !st) begin
        errors++; $display("FAIL rand_resp[%0d]: rdata %h err %b stable %0d want %h/%b", i, rd, e, st, er, ee);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
      last_rdata[d] = 32'd0;
    end
    repeat (2) @(posedge clock);
    test_reset;
    test_preload;
    test_write_read;
    test_held_request;
    test_out_of_range;
    test_reset_mid;
    test_latency_sweep(1);
    test_latency_sweep(2);
    test_latency_sweep(0);
    test_rdata_hold;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
